// File: rtl/vm3_qbus_pkg.sv
// +--------------------------------------------------------------------+
// | vm3_qbus_pkg : shared Qbus constants and target state encoding     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package vm3_qbus_pkg;

  localparam logic [21:0] QBUS_IOPAGE_BASE = 22'o17760000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SKIP   = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_RD     = 3'd3;
  localparam logic [2:0] ST_RPLY_R = 3'd4;
  localparam logic [2:0] ST_WR     = 3'd5;
  localparam logic [2:0] ST_RPLY_W = 3'd6;

endpackage

`default_nettype wire

// File: rtl/vm3_qslave_if.sv
// +--------------------------------------------------------------------+
// | vm3_qslave_if : Qbus target lines plus its request/ack memory port |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface vm3_qslave_if #(
  parameter int ASIZE = 13
) ();
  logic             pin_init;
  logic [15:0]      pin_ad_in;
  logic [5:0]       pin_a_in;
  logic             pin_bs;
  logic             pin_sync;
  logic             pin_wtbt;
  logic             pin_din;
  logic             pin_dout;
  logic             pin_rply;
  logic [15:0]      pin_ad_out;
  logic             pin_ad_ena;
  logic             mem_req;
  logic             mem_we;
  logic [1:0]       mem_sel;
  logic [ASIZE-2:0] mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_ack;

  modport slave (
    input  pin_init, pin_ad_in, pin_a_in, pin_bs, pin_sync, pin_wtbt,
           pin_din, pin_dout, mem_rdata, mem_ack,
    output pin_rply, pin_ad_out, pin_ad_ena, mem_req, mem_we, mem_sel,
           mem_addr, mem_wdata
  );

  modport master (
    output pin_init, pin_ad_in, pin_a_in, pin_bs, pin_sync, pin_wtbt,
           pin_din, pin_dout, mem_rdata, mem_ack,
    input  pin_rply, pin_ad_out, pin_ad_ena, mem_req, mem_we, mem_sel,
           mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/vm3_qslave.sv
// +--------------------------------------------------------------------+
// | vm3_qslave : synchronous Qbus target serving DATI/DATO(B)/DATIO    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vm3_qslave
  import vm3_qbus_pkg::*;
#(
  parameter logic [21:0] BASE   = QBUS_IOPAGE_BASE,
  parameter int          ASIZE  = 13,
  parameter bit          IOPAGE = 1'b1,
  parameter int          WAIT   = 0
) (
  input  logic        pin_clk,
  input  logic        pin_dclo_n,
  vm3_qslave_if.slave bus
);

  localparam logic [3:0] C_WAIT = 4'(WAIT);

  logic [2:0]       state_q, state_d;
  logic             sync_q;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             ackf_q, ackf_d;
  logic             byte_q, byte_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [15:0]      wdata_q, wdata_d;

  logic [21:0]      w_addr;
  logic             w_sel;
  logic             w_sync_rise;
  logic             w_busy;
  logic             w_take_ack;
  logic             w_wait_ok;
  logic             w_done;

  assign w_addr      = {bus.pin_a_in, bus.pin_ad_in};
  assign w_sel       = (w_addr[21:ASIZE] == BASE[21:ASIZE]) && (bus.pin_bs == IOPAGE);
  assign w_sync_rise = bus.pin_sync & ~sync_q;
  assign w_busy      = (state_q == ST_RD) || (state_q == ST_WR);
  assign w_take_ack  = w_busy & ~ackf_q & bus.mem_ack;
  // Written as count+1 > WAIT so the WAIT=0 case is not a constant compare.
  assign w_wait_ok   = ({1'b0, wcnt_q} + 5'd1) > {1'b0, C_WAIT};
  assign w_done      = (ackf_q | w_take_ack) & w_wait_ok;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ackf_d  = ackf_q;
    byte_d  = byte_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    wcnt_d  = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (w_sync_rise) begin
          addr_d  = w_addr[ASIZE-1:0];
          state_d = w_sel ? ST_ADDR : ST_SKIP;
        end
      end
      ST_ADDR: begin
        ackf_d = 1'b0;
        if (bus.pin_din) begin
          state_d = ST_RD;
        end else if (bus.pin_dout) begin
          state_d = ST_WR;
          wdata_d = bus.pin_ad_in;
          byte_d  = bus.pin_wtbt;
        end
      end
      ST_RD: begin
        if (w_take_ack) begin
          rdata_d = bus.mem_rdata;
          ackf_d  = 1'b1;
        end
        if (w_done) state_d = ST_RPLY_R;
      end
      ST_WR: begin
        if (w_take_ack) ackf_d = 1'b1;
        if (w_done) state_d = ST_RPLY_W;
      end
      ST_RPLY_R: if (!bus.pin_din)  state_d = ST_ADDR;
      ST_RPLY_W: if (!bus.pin_dout) state_d = ST_ADDR;
      default:   state_d = state_q;
    endcase

    if (w_busy) wcnt_d = (wcnt_q == 4'hF) ? wcnt_q : wcnt_q + 4'd1;

    // Bus init and a dropped SYNC both withdraw the transaction outright.
    if (bus.pin_init || !bus.pin_sync) begin
      state_d = ST_IDLE;
      ackf_d  = 1'b0;
    end
  end

  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      state_q <= ST_IDLE;
      sync_q  <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= 4'd0;
      ackf_q  <= 1'b0;
      byte_q  <= 1'b0;
      rdata_q <= 16'd0;
      wdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= bus.pin_sync;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      ackf_q  <= ackf_d;
      byte_q  <= byte_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.pin_rply   = (state_q == ST_RPLY_R) || (state_q == ST_RPLY_W);
  assign bus.pin_ad_ena = (state_q == ST_RPLY_R);
  assign bus.pin_ad_out = (state_q == ST_RPLY_R) ? rdata_q : 16'd0;
  assign bus.mem_req    = w_busy & ~ackf_q;
  assign bus.mem_we     = (state_q == ST_WR);
  assign bus.mem_addr   = addr_q[ASIZE-1:1];
  assign bus.mem_wdata  = wdata_q;

  always_comb begin
    bus.mem_sel = 2'b00;
    if (state_q == ST_RD) begin
      bus.mem_sel = 2'b11;
    end else if (state_q == ST_WR) begin
      if (byte_q) bus.mem_sel = addr_q[0] ? 2'b10 : 2'b01;
      else        bus.mem_sel = 2'b11;
    end
  end

endmodule

`default_nettype wire
